// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and result-select enum.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_XOR  = 5'd13;
  localparam logic [4:0] OP_NOR  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_ALU    = 2'd1,
    SEL_MULDIV = 2'd2,
    SEL_ZERO   = 2'd3
  } res_sel_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative signed multiply (shift-add) and restoring divide on operand magnitudes,
// with sign correction applied combinationally to the final registers.
module alu_mc_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH:0]   hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] mag_b_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             div_reg, sa_reg, sb_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  assign mul_sum   = hi_reg + (lo_reg[0] ? {1'b0, mag_b_reg} : '0);
  assign div_shift = {hi_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag_b_reg};
  assign last      = (cnt_reg == SHW'(WIDTH - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      mag_b_reg <= '0;
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
    end else if (load) begin
      sa_reg    <= a[WIDTH-1];
      sb_reg    <= b[WIDTH-1];
      lo_reg    <= a[WIDTH-1] ? -a : a;
      mag_b_reg <= b[WIDTH-1] ? -b : b;
      hi_reg    <= '0;
      cnt_reg   <= '0;
      div_reg   <= is_div;
    end else if (step) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (div_reg) begin
        // Restoring step: keep the trial difference only when it did not go negative.
        if (!div_trial[WIDTH]) begin
          hi_reg <= div_trial;
          lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
        end else begin
          hi_reg <= div_shift;
          lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_reg <= {1'b0, mul_sum[WIDTH:1]};
        lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
      end
    end
  end

  logic [2*WIDTH-1:0] prod_mag;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    prod_mag = {hi_reg[WIDTH-1:0], lo_reg};
    quo      = (sa_reg ^ sb_reg) ? -lo_reg : lo_reg;
    rem      = sa_reg ? -hi_reg[WIDTH-1:0] : hi_reg[WIDTH-1:0];
    if (div_reg) result = {rem, quo};
    else         result = (sa_reg ^ sb_reg) ? -prod_mag : prod_mag;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete at the sampling edge, mul/div run through
// an IDLE/CALC/FIX sequence on the iterative datapath.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               dz,
  output logic               ill
);

  state_t             state_reg, state_next;
  res_sel_t           sel;
  logic [2*WIDTH-1:0] c_reg, c_next;
  logic               done_reg, done_next;
  logic               dz_reg, dz_next;
  logic               ill_reg, ill_next;
  logic               md_load, md_step, md_last;
  logic [2*WIDTH-1:0] md_result;
  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;

  alu_mc_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .load   (md_load),
    .is_div (opcode == OP_DIV),
    .a      (A),
    .b      (B),
    .step   (md_step),
    .last   (md_last),
    .result (md_result)
  );

  assign sh    = B[SHW-1:0];
  assign rot_r = {A, A} >> sh;
  assign rot_l = {A, A} << sh;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SHR:  alu_res = A >> sh;
      OP_SHL:  alu_res = A << sh;
      OP_SHRA: alu_res = $unsigned($signed(A) >>> sh);
      OP_ROR:  alu_res = rot_r[WIDTH-1:0];
      OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NEG:  alu_res = '0 - B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_NOT:  alu_res = ~B;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    sel        = SEL_HOLD;
    done_next  = 1'b0;
    dz_next    = dz_reg;
    ill_next   = ill_reg;
    md_load    = 1'b0;
    md_step    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL || (opcode == OP_DIV && B != '0)) begin
            md_load    = 1'b1;
            state_next = ST_CALC;
          end else begin
            // Divide-by-zero and illegal opcodes finish like single-cycle ops with C=0.
            done_next = 1'b1;
            dz_next   = (opcode == OP_DIV);
            ill_next  = !op_legal(opcode);
            sel       = (opcode == OP_DIV || !op_legal(opcode)) ? SEL_ZERO : SEL_ALU;
          end
        end
      end
      ST_CALC: begin
        md_step = 1'b1;
        if (md_last) state_next = ST_FIX;
      end
      ST_FIX: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
        dz_next    = 1'b0;
        ill_next   = 1'b0;
        sel        = SEL_MULDIV;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (sel)
      SEL_ALU:    c_next = {{WIDTH{1'b0}}, alu_res};
      SEL_MULDIV: c_next = md_result;
      SEL_ZERO:   c_next = '0;
      default:    c_next = c_reg;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= ST_IDLE;
      c_reg     <= '0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
      ill_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      done_reg  <= done_next;
      dz_reg    <= dz_next;
      ill_reg   <= ill_next;
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign C    = c_reg;
  assign dz   = dz_reg;
  assign ill  = ill_reg;

endmodule
